// File: rtl/hwpe_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_cfg_master
// Description : Peripheral-bus initiator that programs and launches one job
//               on an HWPE control slave: acquire a context, write the job
//               registers, write the trigger, wait for the end-of-job event
//               and report completion.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_cfg_master #(
    parameter int unsigned          N_JOB_REGS    = 8,
    parameter logic [31:0]          BASE_ADDR     = 32'h0,
    parameter int unsigned          ID_WIDTH      = 10,
    parameter logic [ID_WIDTH-1:0]  MASTER_ID     = '0,
    parameter int unsigned          ACQ_RETRY_MAX = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             start_i,
    input  logic [N_JOB_REGS-1:0][31:0]      job_regs_i,
    input  logic                             evt_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o,
    output logic [7:0]                       job_id_o,

    output logic                             periph_req_o,
    input  logic                             periph_gnt_i,
    output logic [31:0]                      periph_add_o,
    output logic                             periph_wen_o,
    output logic [3:0]                       periph_be_o,
    output logic [31:0]                      periph_data_o,
    output logic [ID_WIDTH-1:0]              periph_id_o,
    input  logic                             periph_r_valid_i,
    input  logic [31:0]                      periph_r_data_i,
    input  logic [ID_WIDTH-1:0]              periph_r_id_i
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_JOB_REGS - 1);
    localparam logic [7:0]         c_RETRY_MAX = 8'(ACQ_RETRY_MAX);

    // Register map of the control slave, relative to BASE_ADDR
    localparam logic [31:0] c_TRG_ADDR = BASE_ADDR;
    localparam logic [31:0] c_ACQ_ADDR = BASE_ADDR + 32'h0000_0004;
    localparam logic [31:0] c_JOB_ADDR = BASE_ADDR + 32'h0000_0040;

    // FSM encoding
    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_ACQ_REQ  = 4'd1;
    localparam logic [3:0] c_ACQ_RSP  = 4'd2;
    localparam logic [3:0] c_WR_REQ   = 4'd3;
    localparam logic [3:0] c_WR_RSP   = 4'd4;
    localparam logic [3:0] c_TRG_REQ  = 4'd5;
    localparam logic [3:0] c_TRG_RSP  = 4'd6;
    localparam logic [3:0] c_WAIT_EVT = 4'd7;
    localparam logic [3:0] c_DONE     = 4'd8;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [3:0]                   r_state;
    logic [3:0]                   w_state_next;
    logic [N_JOB_REGS-1:0][31:0]  r_job_regs;
    logic [c_IDX_W-1:0]           r_idx;
    logic [7:0]                   r_retry;
    logic [7:0]                   w_retry_inc;
    logic                         r_error;
    logic [7:0]                   r_job_id;
    logic                         w_rsp_valid;
    logic                         w_acq_full;
    logic                         w_start_acc;
    logic                         w_last_reg;
    logic [31:0]                  w_job_offs;
    logic                         w_unused;

    // Only responses carrying our own id belong to this master
    assign w_rsp_valid = periph_r_valid_i && (periph_r_id_i == MASTER_ID);
    // Bit 31 of the acquire read set means no free context was available
    assign w_acq_full  = periph_r_data_i[31];
    assign w_start_acc = (r_state == c_IDLE) && start_i;
    assign w_last_reg  = (r_idx == c_LAST_IDX);
    assign w_retry_inc = r_retry + 8'd1;
    assign w_job_offs  = {{(30 - c_IDX_W){1'b0}}, r_idx, 2'b00};

    // Acquire data beyond the job id and the busy flag carries nothing we use
    assign w_unused = ^periph_r_data_i[30:8];

    // ------------------------------------------------------------------------
    // Next-state logic: one transaction at a time, each REQ waits for gnt and
    // each RSP waits for the matching r_valid
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_state_next = c_ACQ_REQ;
                end
            end
            c_ACQ_REQ: begin
                if (periph_gnt_i) begin
                    w_state_next = c_ACQ_RSP;
                end
            end
            c_ACQ_RSP: begin
                if (w_rsp_valid) begin
                    if (!w_acq_full) begin
                        w_state_next = c_WR_REQ;
                    end else if (w_retry_inc == c_RETRY_MAX) begin
                        w_state_next = c_DONE;
                    end else begin
                        w_state_next = c_ACQ_REQ;
                    end
                end
            end
            c_WR_REQ: begin
                if (periph_gnt_i) begin
                    w_state_next = c_WR_RSP;
                end
            end
            c_WR_RSP: begin
                if (w_rsp_valid) begin
                    w_state_next = w_last_reg ? c_TRG_REQ : c_WR_REQ;
                end
            end
            c_TRG_REQ: begin
                if (periph_gnt_i) begin
                    w_state_next = c_TRG_RSP;
                end
            end
            c_TRG_RSP: begin
                if (w_rsp_valid) begin
                    w_state_next = c_WAIT_EVT;
                end
            end
            c_WAIT_EVT: begin
                if (evt_i) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // State register; clear aborts whatever is in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else if (clear_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job bookkeeping: captured registers, write index, retry count, error
    // flag and the job id handed out by the acquire read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_job_regs <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
            r_job_id   <= '0;
        end else if (clear_i) begin
            r_job_regs <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_error    <= 1'b0;
            r_job_id   <= '0;
        end else begin
            if (w_start_acc) begin
                r_job_regs <= job_regs_i;
                r_idx      <= '0;
                r_retry    <= '0;
                r_error    <= 1'b0;
            end
            if ((r_state == c_ACQ_RSP) && w_rsp_valid) begin
                if (!w_acq_full) begin
                    r_job_id <= periph_r_data_i[7:0];
                end else begin
                    r_retry <= w_retry_inc;
                    if (w_retry_inc == c_RETRY_MAX) begin
                        r_error <= 1'b1;
                    end
                end
            end
            if ((r_state == c_WR_RSP) && w_rsp_valid && !w_last_reg) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Request channel decoded purely from registered state, so add/wen/data
    // stay put until the gnt cycle and nothing depends on gnt or r_valid
    always_comb begin
        periph_req_o  = 1'b0;
        periph_add_o  = '0;
        periph_wen_o  = 1'b1;
        periph_data_o = '0;
        case (r_state)
            c_ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = c_ACQ_ADDR;
            end
            c_WR_REQ: begin
                periph_req_o  = 1'b1;
                periph_add_o  = c_JOB_ADDR + w_job_offs;
                periph_wen_o  = 1'b0;
                periph_data_o = r_job_regs[r_idx];
            end
            c_TRG_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = c_TRG_ADDR;
                periph_wen_o = 1'b0;
            end
            default: begin
                periph_req_o = 1'b0;
            end
        endcase
    end

    assign periph_be_o = 4'hF;
    assign periph_id_o = MASTER_ID;

    assign busy_o   = (r_state != c_IDLE);
    assign done_o   = (r_state == c_DONE);
    assign error_o  = r_error;
    assign job_id_o = r_job_id;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_cfg_master
// Description : Self-checking bench for hwpe_cfg_master. A reactive slave
//               model answers the periph bus; expected transactions are
//               queued by the stimulus and popped by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_cfg_master;

    localparam int unsigned       c_N     = 8;
    localparam logic [31:0]       c_BASE  = 32'h1A10_0000;
    localparam int unsigned       c_IDW   = 10;
    localparam logic [c_IDW-1:0]  c_MID   = 10'd5;
    localparam int unsigned       c_RETRY = 4;

    localparam logic [31:0] c_JOB_A [c_N] = '{
        32'h0000_1000, 32'h0000_2001, 32'hDEAD_BEEF, 32'h1234_5678,
        32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hCAFE_F00D};
    localparam logic [31:0] c_JOB_B [c_N] = '{
        32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404,
        32'h5555_AAAA, 32'hAAAA_5555, 32'h0F0F_F0F0, 32'h7654_3210};

    logic                    clk;
    logic                    rst_n;
    logic                    clear;
    logic                    start;
    logic                    evt;
    logic [c_N-1:0][31:0]    job_regs;
    logic                    busy, done, error;
    logic [7:0]              job_id;
    logic                    req, gnt, wen, r_valid;
    logic [31:0]             add, wdata, r_data;
    logic [3:0]              be;
    logic [c_IDW-1:0]        id, r_id;

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] acq_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    // slave model controls and observations
    bit rand_mode     = 0;
    bit gnt_block     = 0;
    bit inject_bad_id = 0;
    bit pend          = 0;
    bit pend_trig     = 0;
    bit pend_acq      = 0;
    logic [31:0] pend_data;
    int rsp_wait      = 0;
    int gnt_wait      = 0;
    bit trig_rsp_seen = 0;
    int trig_rsp_cyc  = 0;
    int first_grant_cyc = -1;
    int trig_grant_cyc  = -1;

    hwpe_cfg_master #(
        .N_JOB_REGS    (c_N),
        .BASE_ADDR     (c_BASE),
        .ID_WIDTH      (c_IDW),
        .MASTER_ID     (c_MID),
        .ACQ_RETRY_MAX (c_RETRY)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .clear_i          (clear),
        .start_i          (start),
        .job_regs_i       (job_regs),
        .evt_i            (evt),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error),
        .job_id_o         (job_id),
        .periph_req_o     (req),
        .periph_gnt_i     (gnt),
        .periph_add_o     (add),
        .periph_wen_o     (wen),
        .periph_be_o      (be),
        .periph_data_o    (wdata),
        .periph_id_o      (id),
        .periph_r_valid_i (r_valid),
        .periph_r_data_i  (r_data),
        .periph_r_id_i    (r_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.add = a; t.wen = w; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic push_acq(input logic [31:0] rsp);
        push_txn(c_BASE + 32'h4, 1'b1, 32'h0);
        acq_q.push_back(rsp);
    endtask

    task automatic push_job_writes(input bit sel_b);
        for (int i = 0; i < c_N; i++)
            push_txn(c_BASE + 32'h40 + 32'(4 * i), 1'b0, sel_b ? c_JOB_B[i] : c_JOB_A[i]);
        push_txn(c_BASE, 1'b0, 32'h0);
    endtask

    task automatic set_regs(input bit sel_b);
        for (int i = 0; i < c_N; i++)
            job_regs[i] = sel_b ? c_JOB_B[i] : c_JOB_A[i];
    endtask

    // Slave: grants pending requests (optionally stalled), returns one
    // response per grant, serves acquire data from acq_q
    initial begin
        gnt = 1'b0; r_valid = 1'b0; r_data = '0; r_id = c_MID;
        forever begin
            @(negedge clk);
            gnt = 1'b0; r_valid = 1'b0; r_data = '0; r_id = c_MID;
            if (!rst_n || clear) begin
                pend = 0;
            end else if (pend) begin
                if (rsp_wait > 0) begin
                    rsp_wait--;
                end else if (inject_bad_id && pend_acq) begin
                    r_valid = 1'b1; r_id = c_MID + 10'd1; r_data = 32'h0000_0009;
                    inject_bad_id = 0;
                    rsp_wait = 2;
                end else begin
                    r_valid = 1'b1; r_data = pend_data;
                    pend = 0;
                    if (pend_trig) begin
                        trig_rsp_seen = 1;
                        trig_rsp_cyc  = cyc;
                    end
                end
            end else if (req && !(gnt_block && !wen)) begin
                if (gnt_wait > 0) begin
                    gnt_wait--;
                end else begin
                    gnt = 1'b1;
                    pend = 1;
                    pend_trig = (!wen && add == c_BASE);
                    pend_acq  = (wen && add == c_BASE + 32'h4);
                    pend_data = 32'h0;
                    if (pend_acq && acq_q.size() > 0) pend_data = acq_q.pop_front();
                    if (first_grant_cyc < 0) first_grant_cyc = cyc;
                    if (pend_trig) trig_grant_cyc = cyc;
                    rsp_wait = rand_mode ? int'($urandom_range(0, 5)) : 0;
                    gnt_wait = rand_mode ? int'($urandom_range(0, 5)) : 0;
                end
            end
        end
    end

    // Monitor: scoreboard pop on every granted request, protocol checks
    initial begin
        bit          outstanding;
        bit          prev_req, prev_gnt, prev_wen;
        logic [31:0] prev_add, prev_data;
        txn_t        e;
        outstanding = 0; prev_req = 0; prev_gnt = 0;
        prev_wen = 1; prev_add = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || clear) begin
                outstanding = 0;
                prev_req    = 0;
            end else begin
                if (req) begin
                    check("single_outstanding", 32'(outstanding), 32'h0);
                    if (prev_req && !prev_gnt) begin
                        check("stable_add", add, prev_add);
                        check("stable_wen", 32'(wen), 32'(prev_wen));
                        check("stable_data", wdata, prev_data);
                    end
                    if (gnt) begin
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL unexpected_txn: got add=%h wen=%b, expected no transaction", add, wen);
                        end else begin
                            e = exp_q.pop_front();
                            check("txn_add", add, e.add);
                            check("txn_wen", 32'(wen), 32'(e.wen));
                            if (!e.wen) check("txn_data", wdata, e.data);
                        end
                        outstanding = 1;
                    end
                end
                if (r_valid && r_id == c_MID) outstanding = 0;
                if (done) done_cnt++;
                prev_req = req; prev_gnt = gnt; prev_wen = wen;
                prev_add = add; prev_data = wdata;
            end
        end
    end

    task automatic start_job(input bit sel_b, output int c0);
        set_regs(sel_b);
        trig_rsp_seen   = 0;
        first_grant_cyc = -1;
        trig_grant_cyc  = -1;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Pulse evt 'delay' cycles after WAIT_EVT is entered, then check done
    task automatic evt_and_done(input int delay, output int done_cyc);
        int n;
        n = 0;
        done_cyc = -1;
        while (!trig_rsp_seen && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("trigger_response_seen", 32'(trig_rsp_seen), 32'h1);
        if (trig_rsp_seen) begin
            while (cyc < trig_rsp_cyc + 1 + delay) @(negedge clk);
            evt = 1'b1;
            @(negedge clk);
            evt = 1'b0;
            check("done_after_evt", 32'(done), 32'h1);
            check("busy_in_done", 32'(busy), 32'h1);
            done_cyc = cyc;
            @(negedge clk);
            check("done_single_cycle", 32'(done), 32'h0);
            check("idle_after_done", 32'(busy), 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, dc, n, exp_done;
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; evt = 1'b0;
        set_regs(1'b0);
        exp_done = 0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_req", 32'(req), 32'h0);
        check("rst_add", add, 32'h0);
        check("rst_wen", 32'(wen), 32'h1);
        check("rst_be", 32'(be), 32'hF);
        check("rst_data", wdata, 32'h0);
        check("rst_id", 32'(id), 32'h5);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_job_id", 32'(job_id), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: nominal best-case timing, acquire returns 3, evt 10 cycles in
        push_acq(32'h0000_0003);
        push_job_writes(1'b0);
        start_job(1'b0, c0);
        check("t1_busy_cycle1", 32'(busy), 32'h1);
        evt_and_done(10, dc);
        exp_done++;
        check("t1_acq_req_cycle", 32'(first_grant_cyc - c0), 32'd1);
        check("t1_trig_req_cycle", 32'(trig_grant_cyc - c0), 32'd19);
        check("t1_done_cycle", 32'(dc - c0), 32'd32);
        check("t1_job_id", 32'(job_id), 32'h3);
        check("t1_error", 32'(error), 32'h0);
        check("t1_all_txns", 32'(exp_q.size()), 32'h0);
        check("t1_done_count", 32'(done_cnt), 32'(exp_done));

        // T2: random stalls; mid-job start with new regs and stray evt ignored
        rand_mode = 1;
        gnt_wait = int'($urandom_range(0, 5));
        push_acq(32'h0000_00C4);
        push_job_writes(1'b1);
        start_job(1'b1, c0);
        repeat (5) @(negedge clk);
        set_regs(1'b0);
        start = 1'b1; evt = 1'b1;
        @(negedge clk);
        start = 1'b0; evt = 1'b0;
        evt_and_done(3, dc);
        exp_done++;
        check("t2_job_id", 32'(job_id), 32'hC4);
        check("t2_all_txns", 32'(exp_q.size()), 32'h0);
        check("t2_done_count", 32'(done_cnt), 32'(exp_done));
        rand_mode = 0;
        gnt_wait = 0;

        // T3: three busy acquires then success, one below the retry limit
        push_acq(32'hFFFF_FFFF);
        push_acq(32'hFFFF_FFFF);
        push_acq(32'hFFFF_FFFF);
        push_acq(32'h0000_0001);
        push_job_writes(1'b1);
        start_job(1'b1, c0);
        evt_and_done(0, dc);
        exp_done++;
        check("t3_job_id", 32'(job_id), 32'h1);
        check("t3_error", 32'(error), 32'h0);
        check("t3_all_txns", 32'(exp_q.size()), 32'h0);

        // T4: acquire always busy -> abort with error after c_RETRY reads
        for (int i = 0; i < c_RETRY; i++) push_acq(32'hFFFF_FFFF);
        start_job(1'b0, c0);
        n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t4_done_seen", 32'(done), 32'h1);
        check("t4_error", 32'(error), 32'h1);
        exp_done++;
        @(negedge clk);
        check("t4_error_sticky", 32'(error), 32'h1);
        check("t4_idle", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        check("t4_no_writes", 32'(exp_q.size()), 32'h0);
        check("t4_done_count", 32'(done_cnt), 32'(exp_done));

        // T5: clear during a stalled write, then replay with a foreign response
        gnt_block = 1;
        push_acq(32'h0000_0002);
        start_job(1'b0, c0);
        check("t5_error_cleared", 32'(error), 32'h0);
        n = 0;
        while (!(req && !wen) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_write_pending", 32'(req && !wen), 32'h1);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_req_dropped", 32'(req), 32'h0);
        check("t5_busy_cleared", 32'(busy), 32'h0);
        check("t5_job_id_cleared", 32'(job_id), 32'h0);
        gnt_block = 0;
        repeat (3) @(negedge clk);
        check("t5_quiet_after_clear", 32'(exp_q.size()), 32'h0);

        inject_bad_id = 1;
        push_acq(32'h0000_0006);
        push_job_writes(1'b0);
        start_job(1'b0, c0);
        evt_and_done(2, dc);
        exp_done++;
        check("t5_job_id", 32'(job_id), 32'h6);
        check("t5_all_txns", 32'(exp_q.size()), 32'h0);
        check("t5_done_count", 32'(done_cnt), 32'(exp_done));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
